// File: rtl/sliding_window_kxk.sv
// KxK sliding-window generator with line buffers, valid/ready backpressure,
// SOF resync and frame-done pulse. Optional window position outputs: SLIDING_WINDOW_POS_EN.
module sliding_window_kxk #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned K      = 3,
  parameter int unsigned STRIDE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sof,
  input  logic [DATA_W-1:0]          pixel_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [K*K*DATA_W-1:0]      window,
  output logic                       frame_done
`ifdef SLIDING_WINDOW_POS_EN
  ,
  output logic [$clog2(IMG_W)-1:0]   win_x,
  output logic [$clog2(IMG_H)-1:0]   win_y
`endif
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  logic [XW-1:0] col_q, pos_x, dx;
  logic [YW-1:0] row_q, pos_y, dy;
  logic          accept, last_col, last_row, win_hit;

  logic [DATA_W-1:0]            lb_q [K-1][IMG_W];
  logic [DATA_W-1:0]            tap  [K];
  logic [K*K-1:0][DATA_W-1:0]   win_q;

  assign in_ready = out_ready | ~out_valid;
  assign accept   = in_valid & in_ready;
  assign window   = win_q;

  // SOF forces the accepted beat to image position (0,0)
  assign pos_x    = in_sof ? '0 : col_q;
  assign pos_y    = in_sof ? '0 : row_q;
  assign last_col = (pos_x == XW'(IMG_W-1));
  assign last_row = (pos_y == YW'(IMG_H-1));
  assign dx       = pos_x - XW'(K-1);
  assign dy       = pos_y - YW'(K-1);
  assign win_hit  = (pos_x >= XW'(K-1)) && (pos_y >= YW'(K-1)) &&
                    ((dx % XW'(STRIDE)) == '0) && ((dy % YW'(STRIDE)) == '0);

  always_comb begin
    tap[0] = pixel_in;
    for (int unsigned j = 1; j < K; j++) tap[j] = lb_q[j-1][IMG_W-1];
  end

  // Chained line buffers: buffer j delays tap j by one image row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned j = 0; j < K-1; j++)
        for (int unsigned i = 0; i < IMG_W; i++) lb_q[j][i] <= '0;
    end else if (accept) begin
      for (int unsigned j = 0; j < K-1; j++) begin
        lb_q[j][0] <= tap[j];
        for (int unsigned i = 1; i < IMG_W; i++) lb_q[j][i] <= lb_q[j][i-1];
      end
    end
  end

  // Window shifts toward c=0 on every accept; newest column enters at c=K-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q <= '0;
    end else if (accept) begin
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K-1; c++) win_q[r*K+c] <= win_q[r*K+c+1];
        win_q[r*K+K-1] <= tap[K-1-r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= last_row ? '0 : pos_y + YW'(1);
      end else begin
        col_q <= pos_x + XW'(1);
        row_q <= pos_y;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept & last_col & last_row;
      if (accept && win_hit) out_valid <= 1'b1;
      else if (out_ready)    out_valid <= 1'b0;
    end
  end

`ifdef SLIDING_WINDOW_POS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_x <= '0;
      win_y <= '0;
    end else if (accept && win_hit) begin
      win_x <= dx;
      win_y <= dy;
    end
  end
`endif

endmodule

// File: tb/tb_sliding_window_kxk.sv
// Directed bench for sliding_window_kxk on a 5x5 image: K=3/S=1, K=3/S=2 and K=5/S=1 instances.
module tb_sliding_window_kxk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [2:0]   iv, orr, ir, ov, fd;
  logic         sof;
  logic [7:0]   pix;
  logic [71:0]  w0, w1;
  logic [199:0] w2;
`ifdef SLIDING_WINDOW_POS_EN
  logic [2:0]   wx0, wy0, wx1, wy1, wx2, wy2;
`endif

  sliding_window_kxk #(.DATA_W(8), .IMG_W(5), .IMG_H(5), .K(3), .STRIDE(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_sof(sof), .pixel_in(pix),
    .out_valid(ov[0]), .out_ready(orr[0]), .window(w0), .frame_done(fd[0])
`ifdef SLIDING_WINDOW_POS_EN
    , .win_x(wx0), .win_y(wy0)
`endif
  );
  sliding_window_kxk #(.DATA_W(8), .IMG_W(5), .IMG_H(5), .K(3), .STRIDE(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_sof(sof), .pixel_in(pix),
    .out_valid(ov[1]), .out_ready(orr[1]), .window(w1), .frame_done(fd[1])
`ifdef SLIDING_WINDOW_POS_EN
    , .win_x(wx1), .win_y(wy1)
`endif
  );
  sliding_window_kxk #(.DATA_W(8), .IMG_W(5), .IMG_H(5), .K(5), .STRIDE(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_sof(sof), .pixel_in(pix),
    .out_valid(ov[2]), .out_ready(orr[2]), .window(w2), .frame_done(fd[2])
`ifdef SLIDING_WINDOW_POS_EN
    , .win_x(wx2), .win_y(wy2)
`endif
  );

  typedef struct {
    int tlx;
    int tly;
    int acc;   // pixels accepted when the window is taken (gap-free runs)
  } win_vec_t;

  win_vec_t     basic_tab [9];
  win_vec_t     s2_tab    [9];
  win_vec_t     k5_tab    [9];

  int           n_total, n_pass, acc, stall;
  logic [199:0] cap [$];
  int           cap_acc [$];
  int           fd_acc [$];
  logic [7:0]   pq [$];
  bit           sq [$];

  function automatic logic [199:0] sel_win(input int s);
    case (s)
      0:       return {128'b0, w0};
      1:       return {128'b0, w1};
      default: return w2;
    endcase
  endfunction

  // Expected window for a 5-wide image whose pixel value is y*5+x
  function automatic logic [199:0] exp_win(input int k, input int tlx, input int tly);
    logic [199:0] v;
    v = '0;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < k; c++)
        v[(r*k+c)*8 +: 8] = 8'((tly + r) * 5 + tlx + c);
    return v;
  endfunction

  task automatic chk(input string name, input logic [199:0] got, input logic [199:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  // Drive one cycle: set inputs, sample outputs #1 later, then advance one clock
  task automatic one_cycle(input int s, input bit want_valid, input int rmode);
    iv  = '0;
    orr = '1;
    sof = 1'b0;
    if (want_valid && pq.size() > 0) begin
      iv[s] = 1'b1;
      pix   = pq[0];
      sof   = sq[0];
    end
    if (rmode == 2) orr[s] = ($urandom_range(0, 2) != 0);
    else if (rmode == 1 && ov[s] && cap.size() == 1 && stall < 4) orr[s] = 1'b0;
    #1;
    if (rmode == 1 && !orr[s]) begin
      chk("bp_in_ready", 200'(ir[s]), 200'(0));
      chk("bp_window_hold", sel_win(s), exp_win(3, 1, 0));
      stall++;
    end
    if (ov[s] && orr[s]) begin
      cap.push_back(sel_win(s));
      cap_acc.push_back(acc);
    end
    if (fd[s]) fd_acc.push_back(acc);
    if (iv[s] && ir[s]) begin
      void'(pq.pop_front());
      void'(sq.pop_front());
      acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int s, input bit gaps, input int rmode, input int drain);
    int cyc;
    cyc = 0;
    cap.delete(); cap_acc.delete(); fd_acc.delete();
    acc = 0;
    stall = 0;
    while (pq.size() > 0 && cyc < 3000) begin
      one_cycle(s, gaps ? ($urandom_range(0, 3) != 0) : 1'b1, rmode);
      cyc++;
    end
    if (pq.size() > 0) begin
      n_total++;
      $display("FAIL run_timeout: %0d pixels left, required 0", pq.size());
      pq.delete(); sq.delete();
    end
    for (int i = 0; i < drain; i++) one_cycle(s, 1'b0, 0);
  endtask

  task automatic load_frame(input int junk, input bit with_sof);
    for (int i = 0; i < junk; i++) begin pq.push_back(8'(100 + i)); sq.push_back(1'b0); end
    for (int i = 0; i < 25; i++) begin pq.push_back(8'(i)); sq.push_back(with_sof && i == 0); end
  endtask

  task automatic cmp_caps(input string tag, input int k, input win_vec_t tab [9], input int n,
                          input int acc_off, input bit chk_acc);
    chk({tag, "_count"}, 200'(cap.size()), 200'(n));
    for (int i = 0; i < n && i < cap.size(); i++) begin
      chk($sformatf("%s_win%0d", tag, i), cap[i], exp_win(k, tab[i].tlx, tab[i].tly));
      if (chk_acc) chk($sformatf("%s_lat%0d", tag, i), 200'(cap_acc[i]), 200'(tab[i].acc + acc_off));
    end
  endtask

  task automatic cmp_fd(input string tag, input int exp_acc, input bit chk_acc);
    chk({tag, "_fd_count"}, 200'(fd_acc.size()), 200'(1));
    if (chk_acc && fd_acc.size() > 0) chk({tag, "_fd_time"}, 200'(fd_acc[0]), 200'(exp_acc));
  endtask

  initial begin
    basic_tab = '{'{0,0,13}, '{1,0,14}, '{2,0,15}, '{0,1,18}, '{1,1,19},
                  '{2,1,20}, '{0,2,23}, '{1,2,24}, '{2,2,25}};
    s2_tab    = '{'{0,0,13}, '{2,0,15}, '{0,2,23}, '{2,2,25}, '{0,0,0},
                  '{0,0,0},  '{0,0,0},  '{0,0,0},  '{0,0,0}};
    k5_tab    = '{'{0,0,25}, '{0,0,0},  '{0,0,0},  '{0,0,0},  '{0,0,0},
                  '{0,0,0},  '{0,0,0},  '{0,0,0},  '{0,0,0}};
    n_total = 0; n_pass = 0;
    iv = '0; orr = '1; sof = 1'b0; pix = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 200'(ov[0]), 200'(0));
    chk("rst_frame_done", 200'(fd[0]), 200'(0));
    chk("rst_window", {128'b0, w0}, 200'(0));
    chk("rst_in_ready", 200'(ir[0]), 200'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;

    load_frame(0, 1'b0); run(0, 1'b0, 0, 4);
    cmp_caps("basic", 3, basic_tab, 9, 0, 1'b1);
    cmp_fd("basic", 25, 1'b1);

    load_frame(0, 1'b0); run(0, 1'b0, 1, 4);
    chk("bp_stall_cycles", 200'(stall), 200'(4));
    cmp_caps("bp", 3, basic_tab, 9, 0, 1'b0);
    cmp_fd("bp", 0, 1'b0);

    load_frame(0, 1'b0); run(1, 1'b0, 0, 4);
    cmp_caps("stride2", 3, s2_tab, 4, 0, 1'b1);
    cmp_fd("stride2", 25, 1'b1);

    load_frame(0, 1'b0); run(2, 1'b0, 0, 4);
    cmp_caps("k5", 5, k5_tab, 1, 0, 1'b1);
    if (cap.size() > 0) chk("k5_elem44", 200'(cap[0][24*8 +: 8]), 200'(24));

    load_frame(7, 1'b1); run(0, 1'b0, 0, 4);
    cmp_caps("sof", 3, basic_tab, 9, 7, 1'b1);
    cmp_fd("sof", 32, 1'b1);

    for (int i = 0; i < 14; i++) begin pq.push_back(8'(i)); sq.push_back(1'b0); end
    run(0, 1'b0, 0, 0);
    iv = '0;
    chk("midrst_pre_valid", 200'(ov[0]), 200'(1));
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 200'(ov[0]), 200'(0));
    chk("midrst_window", {128'b0, w0}, 200'(0));
    chk("midrst_frame_done", 200'(fd[0]), 200'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    load_frame(0, 1'b0); run(0, 1'b0, 0, 4);
    cmp_caps("after_rst", 3, basic_tab, 9, 0, 1'b1);
    cmp_fd("after_rst", 25, 1'b1);

    load_frame(0, 1'b0); run(0, 1'b1, 2, 6);
    cmp_caps("gaps", 3, basic_tab, 9, 0, 1'b0);
    cmp_fd("gaps", 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
